// File: rtl/stack_pkg.sv
// Shared types and default geometry for the Sky Stacker game-play core.
// Contents:
//   state_e      - game FSM state (move, resolve drop, game over)
//   Def*         - default geometry used as parameter defaults by stack_engine
package stack_pkg;

  typedef enum logic [1:0] {
    StMove    = 2'd0,
    StResolve = 2'd1,
    StOver    = 2'd2
  } state_e;

  localparam int unsigned DefXW        = 10;
  localparam int unsigned DefScreenW   = 640;
  localparam int unsigned DefBlockW0   = 80;
  localparam int unsigned DefBlockH    = 20;
  localparam int unsigned DefBaseY     = 360;
  localparam int unsigned DefStartX    = 280;
  localparam int unsigned DefStep      = 4;
  localparam int unsigned DefMaxLevels = 16;

endpackage

// File: rtl/stack_overlap.sv
// Combinational overlap of the moving block against the top of the tower.
// Ports:
//   a_x_i, a_w_i - left edge and width of the moving block
//   b_x_i, b_w_i - left edge and width of the topmost placed block
//   lo_o, hi_o   - overlap interval [lo, hi), one bit wider than the inputs
//   miss_o       - high when the interval is empty (hi <= lo)
module stack_overlap #(
  parameter int unsigned X_W = 10
) (
  input  logic [X_W-1:0] a_x_i,
  input  logic [X_W-1:0] a_w_i,
  input  logic [X_W-1:0] b_x_i,
  input  logic [X_W-1:0] b_w_i,
  output logic [X_W:0]   lo_o,
  output logic [X_W:0]   hi_o,
  output logic           miss_o
);

  logic [X_W:0] a_lo, a_hi, b_lo, b_hi;

  always_comb begin
    // Extended by one bit so right edges near the screen limit cannot wrap.
    a_lo   = {1'b0, a_x_i};
    b_lo   = {1'b0, b_x_i};
    a_hi   = {1'b0, a_x_i} + {1'b0, a_w_i};
    b_hi   = {1'b0, b_x_i} + {1'b0, b_w_i};
    lo_o   = (a_lo > b_lo) ? a_lo : b_lo;
    hi_o   = (a_hi < b_hi) ? a_hi : b_hi;
    miss_o = (hi_o <= lo_o);
  end

endmodule

// File: rtl/stack_engine.sv
// Sky Stacker game-play core: moves the active block, resolves drops against
// the top of the tower by trimming to the overlap, and tracks height/win/loss.
// Optional feature macro: STACK_AUTO_SWING_EN (block swings on its own, ignoring
// left/right; direction resets to right on reset, start and each placement).
// Ports:
//   clk_i, rst_ni          - clock, asynchronous active-low reset
//   tick_i                 - one-cycle frame strobe
//   left_i, right_i        - level move requests
//   drop_i                 - one-cycle place pulse
//   start_i                - one-cycle restart pulse (only honoured in game over)
//   pos_x_o, pos_y_o       - top-left of the moving block
//   width_o                - moving block width
//   top_x_o, top_w_o       - left edge and width of the topmost placed block
//   height_o               - placed levels, including the base
//   placed_o               - one-cycle pulse on a successful placement
//   game_over_o, win_o     - end flags
module stack_engine
  import stack_pkg::*;
#(
  parameter int unsigned X_W        = DefXW,
  parameter int unsigned SCREEN_W   = DefScreenW,
  parameter int unsigned BLOCK_W0   = DefBlockW0,
  parameter int unsigned BLOCK_H    = DefBlockH,
  parameter int unsigned BASE_Y     = DefBaseY,
  parameter int unsigned START_X    = DefStartX,
  parameter int unsigned STEP       = DefStep,
  parameter int unsigned MAX_LEVELS = DefMaxLevels
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           tick_i,
  input  logic           left_i,
  input  logic           right_i,
  input  logic           drop_i,
  input  logic           start_i,
  output logic [X_W-1:0] pos_x_o,
  output logic [X_W-1:0] pos_y_o,
  output logic [X_W-1:0] width_o,
  output logic [X_W-1:0] top_x_o,
  output logic [X_W-1:0] top_w_o,
  output logic [X_W-1:0] height_o,
  output logic           placed_o,
  output logic           game_over_o,
  output logic           win_o
);

  localparam logic [X_W-1:0] StartX    = X_W'(START_X);
  localparam logic [X_W-1:0] BaseY     = X_W'(BASE_Y);
  localparam logic [X_W-1:0] BlockW0   = X_W'(BLOCK_W0);
  localparam logic [X_W-1:0] BlockH    = X_W'(BLOCK_H);
  localparam logic [X_W-1:0] StepX     = X_W'(STEP);
  localparam logic [X_W-1:0] MaxLevels = X_W'(MAX_LEVELS);
  localparam logic [X_W:0]   ScreenW   = (X_W+1)'(SCREEN_W);

  state_e         state_q, state_d;
  logic [X_W-1:0] pos_x_q, pos_x_d;
  logic [X_W-1:0] pos_y_q, pos_y_d;
  logic [X_W-1:0] width_q, width_d;
  logic [X_W-1:0] top_x_q, top_x_d;
  logic [X_W-1:0] top_w_q, top_w_d;
  logic [X_W-1:0] height_q, height_d;
  logic           placed_q, placed_d;
  logic           game_over_q, game_over_d;
  logic           win_q, win_d;

`ifdef STACK_AUTO_SWING_EN
  // 1 = travelling left, 0 = travelling right.
  logic dir_left_q, dir_left_d;
`endif

  logic [X_W:0]   ov_lo, ov_hi;
  logic           ov_miss;
  logic [X_W:0]   right_sum, right_lim;
  logic [X_W-1:0] pos_right, pos_left;
  logic [X_W-1:0] height_inc;

  stack_overlap #(
    .X_W(X_W)
  ) u_overlap (
    .a_x_i  (pos_x_q),
    .a_w_i  (width_q),
    .b_x_i  (top_x_q),
    .b_w_i  (top_w_q),
    .lo_o   (ov_lo),
    .hi_o   (ov_hi),
    .miss_o (ov_miss)
  );

  // Clamped candidate positions for one step in either direction.
  always_comb begin
    right_sum  = {1'b0, pos_x_q} + {1'b0, StepX};
    right_lim  = ScreenW - {1'b0, width_q};
    pos_right  = (right_sum > right_lim) ? right_lim[X_W-1:0] : right_sum[X_W-1:0];
    pos_left   = (pos_x_q < StepX) ? '0 : pos_x_q - StepX;
    height_inc = height_q + X_W'(1);
  end

  always_comb begin
    state_d     = state_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    width_d     = width_q;
    top_x_d     = top_x_q;
    top_w_d     = top_w_q;
    height_d    = height_q;
    placed_d    = 1'b0;
    game_over_d = game_over_q;
    win_d       = win_q;
`ifdef STACK_AUTO_SWING_EN
    dir_left_d  = dir_left_q;
`endif

    unique case (state_q)
      StMove: begin
        // Drop takes priority over a coincident tick: no move this cycle.
        if (drop_i) begin
          state_d = StResolve;
        end else if (tick_i) begin
`ifdef STACK_AUTO_SWING_EN
          if (!dir_left_q) begin
            pos_x_d = pos_right;
            if (pos_right == right_lim[X_W-1:0]) dir_left_d = 1'b1;
          end else begin
            pos_x_d = pos_left;
            if (pos_left == '0) dir_left_d = 1'b0;
          end
`else
          if (right_i && !left_i) begin
            pos_x_d = pos_right;
          end else if (left_i && !right_i) begin
            pos_x_d = pos_left;
          end
`endif
        end
      end

      StResolve: begin
        if (ov_miss) begin
          state_d     = StOver;
          game_over_d = 1'b1;
          win_d       = 1'b0;
        end else begin
          top_x_d  = ov_lo[X_W-1:0];
          top_w_d  = ov_hi[X_W-1:0] - ov_lo[X_W-1:0];
          width_d  = ov_hi[X_W-1:0] - ov_lo[X_W-1:0];
          height_d = height_inc;
          pos_y_d  = pos_y_q - BlockH;
          pos_x_d  = '0;
          placed_d = 1'b1;
`ifdef STACK_AUTO_SWING_EN
          dir_left_d = 1'b0;
`endif
          if (height_inc == MaxLevels) begin
            state_d     = StOver;
            game_over_d = 1'b1;
            win_d       = 1'b1;
          end else begin
            state_d = StMove;
          end
        end
      end

      StOver: begin
        if (start_i) begin
          state_d     = StMove;
          pos_x_d     = StartX;
          pos_y_d     = BaseY;
          width_d     = BlockW0;
          top_x_d     = StartX;
          top_w_d     = BlockW0;
          height_d    = X_W'(1);
          game_over_d = 1'b0;
          win_d       = 1'b0;
`ifdef STACK_AUTO_SWING_EN
          dir_left_d  = 1'b0;
`endif
        end
      end

      default: state_d = StMove;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StMove;
      pos_x_q     <= StartX;
      pos_y_q     <= BaseY;
      width_q     <= BlockW0;
      top_x_q     <= StartX;
      top_w_q     <= BlockW0;
      height_q    <= X_W'(1);
      placed_q    <= 1'b0;
      game_over_q <= 1'b0;
      win_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      width_q     <= width_d;
      top_x_q     <= top_x_d;
      top_w_q     <= top_w_d;
      height_q    <= height_d;
      placed_q    <= placed_d;
      game_over_q <= game_over_d;
      win_q       <= win_d;
    end
  end

`ifdef STACK_AUTO_SWING_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dir_left_q <= 1'b0;
    end else begin
      dir_left_q <= dir_left_d;
    end
  end
`endif

  assign pos_x_o     = pos_x_q;
  assign pos_y_o     = pos_y_q;
  assign width_o     = width_q;
  assign top_x_o     = top_x_q;
  assign top_w_o     = top_w_q;
  assign height_o    = height_q;
  assign placed_o    = placed_q;
  assign game_over_o = game_over_q;
  assign win_o       = win_q;

endmodule

// File: tb/tb_stack_engine.sv
// Directed self-checking bench for stack_engine in its default (manual move) build.
module tb_stack_engine;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       tick_i = 1'b0;
  logic       left_i = 1'b0;
  logic       right_i = 1'b0;
  logic       drop_i = 1'b0;
  logic       start_i = 1'b0;
  logic [9:0] pos_x_o, pos_y_o, width_o, top_x_o, top_w_o, height_o;
  logic       placed_o, game_over_o, win_o;

  int checks = 0;
  int errors = 0;

  stack_engine dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .tick_i      (tick_i),
    .left_i      (left_i),
    .right_i     (right_i),
    .drop_i      (drop_i),
    .start_i     (start_i),
    .pos_x_o     (pos_x_o),
    .pos_y_o     (pos_y_o),
    .width_o     (width_o),
    .top_x_o     (top_x_o),
    .top_w_o     (top_w_o),
    .height_o    (height_o),
    .placed_o    (placed_o),
    .game_over_o (game_over_o),
    .win_o       (win_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    tick_i = 1'b0; left_i = 1'b0; right_i = 1'b0; drop_i = 1'b0; start_i = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
  endtask

  task automatic ticks(input int n, input logic l, input logic r);
    for (int i = 0; i < n; i++) begin
      tick_i = 1'b1; left_i = l; right_i = r;
      step();
    end
    tick_i = 1'b0; left_i = 1'b0; right_i = 1'b0;
  endtask

  task automatic drop_and_resolve();
    drop_i = 1'b1;
    step();
    drop_i = 1'b0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    ticks(10, 1'b0, 1'b0);
    checks++; if (pos_x_o !== 10'd280) begin errors++; $display("FAIL reset_pos_x got %0d exp 280", pos_x_o); end
    checks++; if (pos_y_o !== 10'd360) begin errors++; $display("FAIL reset_pos_y got %0d exp 360", pos_y_o); end
    checks++; if (width_o !== 10'd80) begin errors++; $display("FAIL reset_width got %0d exp 80", width_o); end
    checks++; if (top_x_o !== 10'd280 || top_w_o !== 10'd80) begin
      errors++; $display("FAIL reset_top got %0d/%0d exp 280/80", top_x_o, top_w_o);
    end
    checks++; if (height_o !== 10'd1) begin errors++; $display("FAIL reset_height got %0d exp 1", height_o); end
    checks++; if ({placed_o, game_over_o, win_o} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b exp 000", {placed_o, game_over_o, win_o});
    end
  endtask

  task automatic test_move_clamp();
    do_reset();
    ticks(1, 1'b0, 1'b1);
    checks++; if (pos_x_o !== 10'd284) begin errors++; $display("FAIL move_first_tick got %0d exp 284", pos_x_o); end
    // Both pressed, and right without tick: no movement.
    ticks(3, 1'b1, 1'b1);
    right_i = 1'b1; step(); step(); right_i = 1'b0;
    checks++; if (pos_x_o !== 10'd284) begin errors++; $display("FAIL move_hold got %0d exp 284", pos_x_o); end
    ticks(99, 1'b0, 1'b1);
    checks++; if (pos_x_o !== 10'd560) begin errors++; $display("FAIL move_clamp_right got %0d exp 560", pos_x_o); end
    ticks(200, 1'b1, 1'b0);
    checks++; if (pos_x_o !== 10'd0) begin errors++; $display("FAIL move_clamp_left got %0d exp 0", pos_x_o); end
  endtask

  task automatic test_drop();
    do_reset();
    ticks(5, 1'b0, 1'b1);
    checks++; if (pos_x_o !== 10'd300) begin errors++; $display("FAIL drop_setup got %0d exp 300", pos_x_o); end
    // Drop coincides with a right tick: drop wins, no move.
    drop_i = 1'b1; tick_i = 1'b1; right_i = 1'b1;
    step();
    drop_i = 1'b0; tick_i = 1'b0; right_i = 1'b0;
    checks++; if (pos_x_o !== 10'd300 || placed_o !== 1'b0 || height_o !== 10'd1) begin
      errors++; $display("FAIL drop_n1 got x=%0d p=%b h=%0d exp x=300 p=0 h=1", pos_x_o, placed_o, height_o);
    end
    step();
    checks++; if (top_x_o !== 10'd300 || top_w_o !== 10'd60) begin
      errors++; $display("FAIL drop_top got %0d/%0d exp 300/60", top_x_o, top_w_o);
    end
    checks++; if (width_o !== 10'd60) begin errors++; $display("FAIL drop_width got %0d exp 60", width_o); end
    checks++; if (height_o !== 10'd2 || pos_y_o !== 10'd340) begin
      errors++; $display("FAIL drop_height got h=%0d y=%0d exp h=2 y=340", height_o, pos_y_o);
    end
    checks++; if (placed_o !== 1'b1 || pos_x_o !== 10'd0) begin
      errors++; $display("FAIL drop_placed got p=%b x=%0d exp p=1 x=0", placed_o, pos_x_o);
    end
    step();
    checks++; if (placed_o !== 1'b0 || game_over_o !== 1'b0) begin
      errors++; $display("FAIL drop_pulse got p=%b go=%b exp 0/0", placed_o, game_over_o);
    end
  endtask

  task automatic test_miss();
    do_reset();
    ticks(70, 1'b1, 1'b0);
    checks++; if (pos_x_o !== 10'd0) begin errors++; $display("FAIL miss_setup got %0d exp 0", pos_x_o); end
    drop_and_resolve();
    checks++; if (game_over_o !== 1'b1 || win_o !== 1'b0 || placed_o !== 1'b0) begin
      errors++; $display("FAIL miss_flags got go=%b w=%b p=%b exp 1/0/0", game_over_o, win_o, placed_o);
    end
    checks++; if (height_o !== 10'd1 || top_x_o !== 10'd280 || top_w_o !== 10'd80) begin
      errors++; $display("FAIL miss_tower got h=%0d tx=%0d tw=%0d exp 1/280/80", height_o, top_x_o, top_w_o);
    end
    for (int i = 0; i < 5; i++) begin
      drop_i = 1'b1; tick_i = 1'b1; right_i = 1'b1;
      step();
    end
    drop_i = 1'b0; tick_i = 1'b0; right_i = 1'b0;
    step();
    checks++; if (pos_x_o !== 10'd0 || height_o !== 10'd1 || game_over_o !== 1'b1) begin
      errors++; $display("FAIL over_hold got x=%0d h=%0d go=%b exp 0/1/1", pos_x_o, height_o, game_over_o);
    end
    start_i = 1'b1; step(); start_i = 1'b0;
    checks++; if (pos_x_o !== 10'd280 || pos_y_o !== 10'd360 || width_o !== 10'd80) begin
      errors++; $display("FAIL start_geom got x=%0d y=%0d w=%0d exp 280/360/80", pos_x_o, pos_y_o, width_o);
    end
    checks++; if (game_over_o !== 1'b0 || win_o !== 1'b0 || height_o !== 10'd1) begin
      errors++; $display("FAIL start_flags got go=%b w=%b h=%0d exp 0/0/1", game_over_o, win_o, height_o);
    end
    // Back in MOVE: moves work again and start is ignored.
    ticks(1, 1'b0, 1'b1);
    start_i = 1'b1; step(); start_i = 1'b0;
    checks++; if (pos_x_o !== 10'd284) begin errors++; $display("FAIL start_in_move got %0d exp 284", pos_x_o); end
  endtask

  task automatic test_win();
    do_reset();
    for (int i = 0; i < 15; i++) begin
      if (i > 0) ticks(70, 1'b0, 1'b1);
      drop_and_resolve();
      checks++; if (height_o !== 10'(i + 2)) begin
        errors++; $display("FAIL win_height_%0d got %0d exp %0d", i, height_o, i + 2);
      end
    end
    checks++; if (game_over_o !== 1'b1 || win_o !== 1'b1 || placed_o !== 1'b1) begin
      errors++; $display("FAIL win_flags got go=%b w=%b p=%b exp 1/1/1", game_over_o, win_o, placed_o);
    end
    checks++; if (pos_y_o !== 10'd60 || top_w_o !== 10'd80 || top_x_o !== 10'd280) begin
      errors++; $display("FAIL win_geom got y=%0d tw=%0d tx=%0d exp 60/80/280", pos_y_o, top_w_o, top_x_o);
    end
    ticks(3, 1'b0, 1'b1);
    checks++; if (pos_x_o !== 10'd0 || height_o !== 10'd16 || win_o !== 1'b1) begin
      errors++; $display("FAIL win_hold got x=%0d h=%0d w=%b exp 0/16/1", pos_x_o, height_o, win_o);
    end
  endtask

  task automatic test_reset_mid_resolve();
    do_reset();
    ticks(5, 1'b0, 1'b1);
    drop_i = 1'b1; step(); drop_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    checks++; if (pos_x_o !== 10'd280 || height_o !== 10'd1) begin
      errors++; $display("FAIL rst_async got x=%0d h=%0d exp 280/1", pos_x_o, height_o);
    end
    step();
    rst_ni = 1'b1;
    step();
    checks++; if (height_o !== 10'd1 || placed_o !== 1'b0 || top_w_o !== 10'd80 || width_o !== 10'd80) begin
      errors++; $display("FAIL rst_release got h=%0d p=%b tw=%0d w=%0d exp 1/0/80/80",
                         height_o, placed_o, top_w_o, width_o);
    end
  endtask

  initial begin
    test_reset();
    test_move_clamp();
    test_drop();
    test_miss();
    test_win();
    test_reset_mid_resolve();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
